modrm_fetch: RTL and testbench
==============================

Name: modrm_fetch

Overview:
- Upstream byte-collector for ModRMDecode.
- On a microcode request it pulls the ModR/M byte, plus 0, 1 or 2 displacement bytes, from the instruction prefetch FIFO.
- It sign-extends disp8, registers the ModR/M byte and displacement, then issues a one-cycle start pulse to the decoder.
- It reports the consumed byte count so the IP-advance logic can update IP.

Parameters:
- SIGN_EXTEND_DISP8, 1: when 1, a MOD=01 displacement is sign-extended from bit 7. When 0, it is zero-extended (test/debug only).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request from microcode to fetch a ModR/M sequence
- flush  input  1  abort: pipeline redirect or fault
- fifo_byte  input  8  head byte of the prefetch FIFO
- fifo_valid  input  1  fifo_byte holds valid data
- fifo_rd_en  output  1  pop strobe; the byte is consumed on the same rising edge
- modrm  output  8  captured ModR/M byte, to ModRMDecode.modrm
- displacement  output  16  captured, extended displacement, to ModRMDecode.displacement
- decode_start  output  1  one-cycle pulse, to ModRMDecode.start
- done  output  1  one-cycle pulse, coincident with decode_start
- busy  output  1  high while in a FETCH_* state
- length  output  2  bytes consumed in the last sequence: 1, 2 or 3

Behaviour:
- Reset (asynchronous, any state): state=IDLE; all outputs 0; modrm=8'h00; displacement=16'h0000; length=0.
- States: IDLE, FETCH_MODRM, FETCH_DISP_LO, FETCH_DISP_HI, DONE.
- fifo_rd_en = fifo_valid & !flush & state in {FETCH_MODRM, FETCH_DISP_LO, FETCH_DISP_HI}. It is combinational. There is at most one pop per cycle.
- A FETCH_* state with fifo_valid=0 holds with no pop. Stalls are unbounded.
- IDLE or DONE, start=1 → FETCH_MODRM.
  - displacement is cleared to 0 and length to 0 on that edge.
  - start in FETCH_* states is ignored.
- FETCH_MODRM, on pop:
  - modrm <= fifo_byte; length <= 1.
  - Displacement byte count: MOD=11 → 0; MOD=00 and RM=110 → 2 (direct disp16); other MOD=00 → 0; MOD=01 → 1; MOD=10 → 2.
  - 0 bytes → DONE; otherwise → FETCH_DISP_LO.
- FETCH_DISP_LO, on pop:
  - displacement[7:0] <= fifo_byte; length increments.
  - If 1 byte is needed: displacement[15:8] <= {8{fifo_byte[7]}} (or 0 when SIGN_EXTEND_DISP8=0) → DONE.
  - Otherwise → FETCH_DISP_HI.
- FETCH_DISP_HI, on pop: displacement[15:8] <= fifo_byte; length increments; → DONE.
- DONE: decode_start=1 and done=1 for exactly this cycle. Next state is FETCH_MODRM if start=1, else IDLE.
- Output stability: modrm, displacement and length hold after DONE until the next accepted start. ModRMDecode may sample them any time after decode_start.
- Latency, FIFO always valid: start edge → DONE visible 2 cycles after start for 0 disp bytes, 3 cycles for 1 byte, 4 cycles for 2 bytes.
- flush:
  - Has priority over start and over pops.
  - In any state, flush=1 → IDLE on the next edge.
  - No pop, no decode_start and no done in that cycle. Registered data is unchanged.
  - flush in DONE suppresses that cycle's decode_start.
- MOD/RM used for the disp-count decision come from fifo_byte in the pop cycle, not from the modrm register.
- Disp16 arithmetic is little-endian: the low byte is fetched first. No wrap concerns, as there is no addition here.

Decomposition:
- Package modrm_fetch_pkg holds:
  - enum fetch_state_t;
  - constants MOD_REG=2'b11, MOD_NODISP=2'b00, MOD_DISP8=2'b01, MOD_DISP16=2'b10, RM_DIRECT=3'b110;
  - function disp_bytes(modrm) returning 2 bits.
- No sub-module. It is a single FSM plus capture registers, about 150–200 lines.

Test Plan:
- FIFO streams 8'hD3 (MOD=11), start pulsed → one pop; modrm=8'hD3, displacement=0, length=1, decode_start 2 cycles after start.
- FIFO streams 8'h06, 8'h34, 8'h12 → three pops; displacement=16'h1234, length=3, single decode_start. A chained ModRMDecode with that input produces EA=16'h1234.
- FIFO streams 8'h43, 8'hF0 → displacement=16'hFFF0, length=2. With SIGN_EXTEND_DISP8=0 → 16'h00F0.
- 8'h80 valid, then fifo_valid=0 for 5 cycles, then 8'h00, 8'h10 → no pops and busy=1 during the gap; final displacement=16'h1000; decode_start exactly once.
- Byte 8'h83 popped, then flush asserted in FETCH_DISP_LO → fifo_rd_en=0 that cycle, IDLE next, no decode_start. A new start then consumes a fresh sequence correctly.
- Reset asserted mid-FETCH_DISP_HI, asynchronously between edges → outputs zero immediately, state IDLE; start ignored while reset is high.

Source files
------------

// File: rtl/modrm_fetch_pkg.sv
// Shared types and helpers for the ModR/M byte collector.
// Holds the FSM state enum, MOD/RM field constants and the disp-count decode.
package modrm_fetch_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH_MODRM,
      ST_FETCH_DISP_LO,
      ST_FETCH_DISP_HI,
      ST_DONE
   } fetch_state_t;

   localparam logic [1:0] MOD_REG    = 2'b11;
   localparam logic [1:0] MOD_NODISP = 2'b00;
   localparam logic [1:0] MOD_DISP8  = 2'b01;
   localparam logic [1:0] MOD_DISP16 = 2'b10;
   localparam logic [2:0] RM_DIRECT  = 3'b110;

   // Number of displacement bytes that follow a ModR/M byte (16-bit mode).
   function automatic logic [1:0] disp_bytes(input logic [7:0] modrm);
      logic [1:0] n;
      n = 2'd0;
      unique case (modrm[7:6])
         MOD_NODISP: n = (modrm[2:0] == RM_DIRECT) ? 2'd2 : 2'd0;
         MOD_DISP8:  n = 2'd1;
         MOD_DISP16: n = 2'd2;
         MOD_REG:    n = 2'd0;
         default:    n = 2'd0;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/modrm_fetch.sv
// ModR/M byte collector: pops ModR/M plus 0..2 displacement bytes from the
// prefetch FIFO, extends disp8, and pulses decode_start/done to ModRMDecode.
// Ports: clk, reset (async, active-high); start, flush from microcode;
//   fifo_byte/fifo_valid/fifo_rd_en to the prefetch FIFO;
//   modrm, displacement, decode_start to the decoder; done, busy, length
//   (bytes consumed) to microcode and the IP-advance logic.
module modrm_fetch
   import modrm_fetch_pkg::*;
#(
   parameter bit SIGN_EXTEND_DISP8 = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        flush,
   input  logic [7:0]  fifo_byte,
   input  logic        fifo_valid,
   output logic        fifo_rd_en,
   output logic [7:0]  modrm,
   output logic [15:0] displacement,
   output logic        decode_start,
   output logic        done,
   output logic        busy,
   output logic [1:0]  length
);

   fetch_state_t state_q, state_d;
   logic [7:0]   modrm_q, modrm_d;
   logic [15:0]  disp_q, disp_d;
   logic [1:0]   len_q, len_d;
   logic [1:0]   need_q, need_d;
   logic         in_fetch;
   logic [1:0]   need_now;

   assign in_fetch = (state_q == ST_FETCH_MODRM) ||
                     (state_q == ST_FETCH_DISP_LO) ||
                     (state_q == ST_FETCH_DISP_HI);

   // Decision uses the byte being popped, not the modrm register.
   assign need_now = disp_bytes(fifo_byte);

   assign fifo_rd_en   = fifo_valid & ~flush & in_fetch;
   assign busy         = in_fetch;
   assign decode_start = (state_q == ST_DONE) & ~flush;
   assign done         = decode_start;
   assign modrm        = modrm_q;
   assign displacement = disp_q;
   assign length       = len_q;

   always_comb begin
      state_d = state_q;
      modrm_d = modrm_q;
      disp_d  = disp_q;
      len_d   = len_q;
      need_d  = need_q;
      if (flush) begin
         state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state_d = ST_FETCH_MODRM;
                  disp_d  = 16'h0000;
                  len_d   = 2'd0;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_FETCH_MODRM: begin
               if (fifo_rd_en) begin
                  modrm_d = fifo_byte;
                  len_d   = 2'd1;
                  need_d  = need_now;
                  state_d = (need_now == 2'd0) ? ST_DONE
                                               : ST_FETCH_DISP_LO;
               end
            end
            ST_FETCH_DISP_LO: begin
               if (fifo_rd_en) begin
                  disp_d[7:0] = fifo_byte;
                  len_d       = len_q + 2'd1;
                  if (need_q == 2'd1) begin
                     disp_d[15:8] = SIGN_EXTEND_DISP8 ? {8{fifo_byte[7]}}
                                                      : 8'h00;
                     state_d = ST_DONE;
                  end else begin
                     state_d = ST_FETCH_DISP_HI;
                  end
               end
            end
            ST_FETCH_DISP_HI: begin
               if (fifo_rd_en) begin
                  disp_d[15:8] = fifo_byte;
                  len_d        = len_q + 2'd1;
                  state_d      = ST_DONE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         modrm_q <= 8'h00;
         disp_q  <= 16'h0000;
         len_q   <= 2'd0;
         need_q  <= 2'd0;
      end else begin
         state_q <= state_d;
         modrm_q <= modrm_d;
         disp_q  <= disp_d;
         len_q   <= len_d;
         need_q  <= need_d;
      end
   end

endmodule

// File: tb/tb_modrm_fetch.sv
// Directed bench for modrm_fetch with a queue-modelled prefetch FIFO.
// A second instance checks the zero-extended disp8 variant.
module tb_modrm_fetch;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        flush;
   logic [7:0]  fifo_byte;
   logic        fifo_valid;
   logic        fifo_rd_en;
   logic [7:0]  modrm;
   logic [15:0] displacement;
   logic        decode_start;
   logic        done;
   logic        busy;
   logic [1:0]  length;

   logic        rd_en_z;
   logic [7:0]  modrm_z;
   logic [15:0] disp_z;
   logic        dec_z;
   logic        done_z;
   logic        busy_z;
   logic [1:0]  len_z;

   modrm_fetch #(.SIGN_EXTEND_DISP8(1'b1)) dut (
      .clk(clk), .reset(reset), .start(start), .flush(flush),
      .fifo_byte(fifo_byte), .fifo_valid(fifo_valid),
      .fifo_rd_en(fifo_rd_en), .modrm(modrm),
      .displacement(displacement), .decode_start(decode_start),
      .done(done), .busy(busy), .length(length)
   );

   modrm_fetch #(.SIGN_EXTEND_DISP8(1'b0)) dut_z (
      .clk(clk), .reset(reset), .start(start), .flush(flush),
      .fifo_byte(fifo_byte), .fifo_valid(fifo_valid),
      .fifo_rd_en(rd_en_z), .modrm(modrm_z),
      .displacement(disp_z), .decode_start(dec_z),
      .done(done_z), .busy(busy_z), .length(len_z)
   );

   always #5 clk = ~clk;

   logic [7:0] fq[$];
   logic       hold;
   int n_chk, n_err;
   int n_pop, n_dec, n_done, cyc, dec_cyc;
   logic rd_s, dec_s, done_s, busy_s;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive_fifo();
      fifo_valid = (fq.size() > 0) && !hold;
      fifo_byte  = (fq.size() > 0) ? fq[0] : 8'h00;
   endtask

   task automatic step();
      @(negedge clk);
      rd_s   = fifo_rd_en;
      dec_s  = decode_start;
      done_s = done;
      busy_s = busy;
      if (rd_s) n_pop++;
      if (dec_s) begin
         n_dec++;
         dec_cyc = cyc;
      end
      if (done_s) n_done++;
      @(posedge clk);
      #1;
      cyc++;
      if (rd_s && fq.size() > 0) void'(fq.pop_front());
      drive_fifo();
   endtask

   task automatic launch();
      n_pop = 0; n_dec = 0; n_done = 0; cyc = 0; dec_cyc = -1;
      drive_fifo();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic wait_dec(input string tag);
      int k;
      k = 0;
      while (n_dec == 0 && k < 20) begin
         step();
         k++;
      end
      check({tag, "_seen"}, 32'(n_dec != 0), 32'd1);
      step();
      step();
   endtask

   initial begin
      n_chk = 0; n_err = 0;
      reset = 1'b1; start = 1'b0; flush = 1'b0; hold = 1'b0;
      drive_fifo();
      n_pop = 0; n_dec = 0; n_done = 0; cyc = 0; dec_cyc = -1;
      step();
      step();
      check("rst_busy", 32'(busy), 0);
      check("rst_modrm", 32'(modrm), 0);
      check("rst_disp", 32'(displacement), 0);
      check("rst_len", 32'(length), 0);
      check("rst_dec", 32'(decode_start), 0);
      check("rst_outs_z", {rd_en_z, modrm_z, disp_z, dec_z,
                           done_z, busy_z, len_z}, 0);
      reset = 1'b0;
      step();

      // Register form: one byte, DONE two cycles after start.
      fq.push_back(8'hD3);
      launch();
      wait_dec("d3");
      check("d3_lat", 32'(dec_cyc), 2);
      check("d3_pops", 32'(n_pop), 1);
      check("d3_modrm", 32'(modrm), 32'hD3);
      check("d3_disp", 32'(displacement), 0);
      check("d3_len", 32'(length), 1);
      check("d3_done", 32'(n_done), 1);

      // Direct disp16 address.
      fq.push_back(8'h06); fq.push_back(8'h34); fq.push_back(8'h12);
      launch();
      wait_dec("d16");
      check("d16_lat", 32'(dec_cyc), 4);
      check("d16_pops", 32'(n_pop), 3);
      check("d16_disp", 32'(displacement), 32'h1234);
      check("d16_len", 32'(length), 3);
      check("d16_ndec", 32'(n_dec), 1);

      // Negative disp8.
      fq.push_back(8'h43); fq.push_back(8'hF0);
      launch();
      wait_dec("d8");
      check("d8_lat", 32'(dec_cyc), 3);
      check("d8_disp", 32'(displacement), 32'hFFF0);
      check("d8_disp_z", 32'(disp_z), 32'h00F0);
      check("d8_len", 32'(length), 2);
      check("d8_modrm", 32'(modrm), 32'h43);

      // FIFO stall in the middle of a disp16.
      fq.push_back(8'h80);
      launch();
      step();
      hold = 1'b1;
      drive_fifo();
      for (int i = 0; i < 5; i++) begin
         step();
         check("gap_rd", 32'(rd_s), 0);
         check("gap_busy", 32'(busy_s), 1);
      end
      fq.push_back(8'h00); fq.push_back(8'h10);
      hold = 1'b0;
      drive_fifo();
      wait_dec("gap");
      check("gap_disp", 32'(displacement), 32'h1000);
      check("gap_len", 32'(length), 3);
      check("gap_pops", 32'(n_pop), 3);
      check("gap_ndec", 32'(n_dec), 1);

      // Flush in FETCH_DISP_LO.
      fq.push_back(8'h83); fq.push_back(8'h55);
      launch();
      step();
      flush = 1'b1;
      step();
      check("fl_rd", 32'(rd_s), 0);
      check("fl_busy", 32'(busy), 0);
      flush = 1'b0;
      step();
      step();
      check("fl_pops", 32'(n_pop), 1);
      check("fl_ndec", 32'(n_dec), 0);
      check("fl_modrm", 32'(modrm), 32'h83);
      check("fl_len", 32'(length), 1);
      fq.delete();
      fq.push_back(8'hC0);
      launch();
      wait_dec("fl2");
      check("fl2_modrm", 32'(modrm), 32'hC0);
      check("fl2_len", 32'(length), 1);
      check("fl2_disp", 32'(displacement), 0);

      // Async reset while stalled in FETCH_DISP_HI.
      fq.push_back(8'h06); fq.push_back(8'h34);
      launch();
      step();
      step();
      step();
      check("ar_busy_pre", 32'(busy_s), 1);
      #2;
      reset = 1'b1;
      #1;
      check("ar_busy", 32'(busy), 0);
      check("ar_modrm", 32'(modrm), 0);
      check("ar_disp", 32'(displacement), 0);
      check("ar_len", 32'(length), 0);
      start = 1'b1;
      step();
      step();
      check("ar_busy_st", 32'(busy), 0);
      check("ar_ndec", 32'(n_dec), 0);
      start = 1'b0;
      reset = 1'b0;
      step();
      check("ar_idle", 32'(busy), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
